// File: rtl/delta_trig_decoder.sv
// rtl/delta_trig_decoder.sv - validates 1-0-0-1 trigger headers and emits one pulse per good header
module delta_trig_decoder #(
    parameter int CNT_W = 16,
    parameter int GAP_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_live,
    input  logic             in_trig,
    input  logic [GAP_W-1:0] user_min_gap,
    input  logic             clr_cnt,
    output logic             trig_out,
    output logic [CNT_W-1:0] trig_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [GAP_W-1:0] last_gap,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        H1   = 2'd1,
        H2   = 2'd2,
        H3   = 2'd3
    } state_t;

    state_t           state;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] start_gap;
    logic             close_flag;
    logic             seen_one;

    logic             hdr_start;
    logic             hdr_err;
    logic             hdr_done;
    logic             accept;
    logic             err_evt;
    logic             start_close;

    // Classify the current sample: header start, malformed header, or completed header
    always_comb begin
        hdr_start = 1'b0;
        hdr_err   = 1'b0;
        hdr_done  = 1'b0;
        if (in_live) begin
            case (state)
                IDLE: hdr_start = in_trig;
                H1, H2: begin
                    // A 1 where a 0 was expected is both an error and a fresh header start
                    if (in_trig) begin
                        hdr_err   = 1'b1;
                        hdr_start = 1'b1;
                    end
                end
                H3: begin
                    if (in_trig) hdr_done = 1'b1;
                    else         hdr_err  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A completed header counts as an error instead of a trigger when it started too soon
    assign accept      = hdr_done && !close_flag;
    assign err_evt     = hdr_err || (hdr_done && close_flag);
    assign start_close = seen_one && (gap_cnt < user_min_gap);

    // Header FSM; busy is registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else if (!in_live) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_trig) begin
                        state <= H1;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                H1: begin
                    state <= in_trig ? H1 : H2;
                    busy  <= 1'b1;
                end
                H2: begin
                    state <= in_trig ? H1 : H3;
                    busy  <= 1'b1;
                end
                H3: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Gap tracking: cycles since the last header start, plus the too-close decision for it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt    <= '0;
            start_gap  <= '0;
            close_flag <= 1'b0;
            seen_one   <= 1'b0;
        end else if (!in_live) begin
            gap_cnt    <= '0;
            close_flag <= 1'b0;
            seen_one   <= 1'b0;
        end else if (hdr_start) begin
            gap_cnt    <= GAP_W'(1);
            start_gap  <= gap_cnt;
            close_flag <= start_close;
            seen_one   <= 1'b1;
        end else if (gap_cnt != {GAP_W{1'b1}}) begin
            gap_cnt    <= gap_cnt + GAP_W'(1);
        end
    end

    // One-cycle trigger pulse the cycle after an accepted header's final 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trig_out <= 1'b0;
        else        trig_out <= accept;
    end

    // Saturating statistics; a clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_cnt <= '0;
            err_cnt  <= '0;
            last_gap <= '0;
        end else if (clr_cnt) begin
            trig_cnt <= '0;
            err_cnt  <= '0;
            last_gap <= '0;
        end else begin
            if (accept) begin
                last_gap <= start_gap;
                if (trig_cnt != {CNT_W{1'b1}}) trig_cnt <= trig_cnt + CNT_W'(1);
            end
            if (err_evt && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_delta_trig_decoder.sv
// tb/tb_delta_trig_decoder.sv - randomized and directed checks of delta_trig_decoder against a timestamp model
module tb_delta_trig_decoder;

    localparam int CNT_W = 5;
    localparam int GAP_W = 32;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
    localparam longint GAP_MAX = (64'd1 << GAP_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_live;
    logic             in_trig;
    logic [GAP_W-1:0] user_min_gap;
    logic             clr_cnt;
    logic             trig_out;
    logic [CNT_W-1:0] trig_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [GAP_W-1:0] last_gap;
    logic             busy;

    delta_trig_decoder #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_live      (in_live),
        .in_trig      (in_trig),
        .user_min_gap (user_min_gap),
        .clr_cnt      (clr_cnt),
        .trig_out     (trig_out),
        .trig_cnt     (trig_cnt),
        .err_cnt      (err_cnt),
        .last_gap     (last_gap),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    bit rand_clr = 0;

    // Reference model: how much of the 1-0-0-1 pattern is matched, and cycle timestamps
    bit     pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int     matched;
    longint cyc;
    longint ref_cyc;
    longint m_start_gap;
    bit     m_seen;
    bit     m_close;
    longint exp_trig_cnt;
    longint exp_err_cnt;
    longint exp_last_gap;
    bit     exp_trig;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        matched      = 0;
        ref_cyc      = cyc;
        m_start_gap  = 0;
        m_seen       = 0;
        m_close      = 0;
        exp_trig_cnt = 0;
        exp_err_cnt  = 0;
        exp_last_gap = 0;
        exp_trig     = 0;
    endtask

    task automatic model_step();
        longint g;
        bit start = 0;
        bit err   = 0;
        bit done  = 0;
        if (!in_live) begin
            matched = 0;
            ref_cyc = cyc + 1;
            m_seen  = 0;
            m_close = 0;
        end else begin
            g = cyc - ref_cyc;
            if (g > GAP_MAX) g = GAP_MAX;
            if (matched == 0) begin
                start = in_trig;
            end else if (in_trig == pat[matched]) begin
                if (matched == 3) begin
                    done    = 1;
                    matched = 0;
                end else begin
                    matched++;
                end
            end else begin
                err = 1;
                if (in_trig) start = 1;
                else         matched = 0;
            end
            if (start) begin
                m_start_gap = g;
                m_close     = m_seen && (g < longint'(user_min_gap));
                m_seen      = 1;
                ref_cyc     = cyc;
                matched     = 1;
            end
        end
        exp_trig = done && !m_close;
        if (done && m_close) err = 1;
        if (clr_cnt) begin
            exp_trig_cnt = 0;
            exp_err_cnt  = 0;
            exp_last_gap = 0;
        end else begin
            if (exp_trig) begin
                exp_last_gap = m_start_gap;
                if (exp_trig_cnt < CNT_MAX) exp_trig_cnt++;
            end
            if (err && exp_err_cnt < CNT_MAX) exp_err_cnt++;
        end
        cyc++;
    endtask

    task automatic tick();
        if (rand_clr) clr_cnt = ($urandom_range(0, 63) == 0);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("trig_out", 64'(trig_out), 64'(exp_trig));
        check_eq("busy", 64'(busy), 64'(matched != 0));
        check_eq("trig_cnt", 64'(trig_cnt), 64'(exp_trig_cnt));
        check_eq("err_cnt", 64'(err_cnt), 64'(exp_err_cnt));
        check_eq("last_gap", 64'(last_gap), 64'(exp_last_gap));
        if (trig_out) pulses++;
    endtask

    task automatic send_bit(input bit b);
        in_trig = b;
        tick();
    endtask

    task automatic send_hdr();
        send_bit(1); send_bit(0); send_bit(0); send_bit(1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(0);
    endtask

    task automatic clear_tick();
        in_trig = 0;
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
    endtask

    initial begin
        int p0;
        longint lg;
        cyc          = 0;
        rst_n        = 0;
        in_live      = 1;
        in_trig      = 0;
        user_min_gap = 10;
        clr_cnt      = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_trig_out", 64'(trig_out), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_trig_cnt", 64'(trig_cnt), 64'd0);
        check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
        check_eq("rst_last_gap", 64'(last_gap), 64'd0);
        rst_n = 1;

        // Two good headers 24 cycles apart
        p0 = pulses;
        send_hdr();
        idle(20);
        send_hdr();
        idle(1);
        check_eq("t1_trig_cnt", 64'(trig_cnt), 64'd2);
        check_eq("t1_err_cnt", 64'(err_cnt), 64'd0);
        check_eq("t1_last_gap", 64'(last_gap), 64'd24);
        check_eq("t1_pulses", 64'(pulses - p0), 64'd2);

        // Malformed headers with restarts
        user_min_gap = 0;
        clear_tick();
        send_bit(1); send_bit(1); send_bit(0); send_bit(0); send_bit(1);
        idle(1);
        check_eq("t2a_err_cnt", 64'(err_cnt), 64'd1);
        check_eq("t2a_trig_cnt", 64'(trig_cnt), 64'd1);
        send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(0); send_bit(1);
        idle(1);
        check_eq("t2b_err_cnt", 64'(err_cnt), 64'd2);
        check_eq("t2b_trig_cnt", 64'(trig_cnt), 64'd2);
        send_bit(1); send_bit(0); send_bit(0); send_bit(0);
        check_eq("t2c_err_cnt", 64'(err_cnt), 64'd3);
        check_eq("t2c_busy", 64'(busy), 64'd0);
        idle(2);

        // Second header too close to the first
        clear_tick();
        user_min_gap = 10;
        idle(15);
        send_hdr();
        idle(1);
        lg = exp_last_gap;
        idle(1);
        send_hdr();
        idle(1);
        check_eq("t3_trig_cnt", 64'(trig_cnt), 64'd1);
        check_eq("t3_err_cnt", 64'(err_cnt), 64'd1);
        check_eq("t3_last_gap", 64'(last_gap), 64'(lg));

        // Drop live mid-header, then first header after live is never close
        p0 = pulses;
        send_bit(1); send_bit(0);
        in_live = 0;
        send_bit(0);
        check_eq("t4_busy", 64'(busy), 64'd0);
        check_eq("t4_err_cnt", 64'(err_cnt), 64'd1);
        in_live = 1;
        user_min_gap = 100;
        idle(2);
        send_hdr();
        idle(1);
        check_eq("t4_trig_cnt", 64'(trig_cnt), 64'd2);
        check_eq("t4_pulses", 64'(pulses - p0), 64'd1);

        // Saturation and clear racing a completing header
        user_min_gap = 0;
        clear_tick();
        p0 = pulses;
        for (int i = 0; i < int'(CNT_MAX) + 2; i++) begin
            send_hdr();
            idle(1);
        end
        check_eq("t5_trig_sat", 64'(trig_cnt), 64'(CNT_MAX));
        check_eq("t5_pulses", 64'(pulses - p0), 64'(CNT_MAX + 2));
        send_bit(1); send_bit(0); send_bit(0);
        clr_cnt = 1;
        send_bit(1);
        clr_cnt = 0;
        check_eq("t5_clr_pulse", 64'(trig_out), 64'd1);
        check_eq("t5_clr_trig_cnt", 64'(trig_cnt), 64'd0);
        check_eq("t5_clr_last_gap", 64'(last_gap), 64'd0);
        idle(2);

        // Asynchronous reset while in H3
        send_hdr();
        send_bit(1); send_bit(0); send_bit(0);
        rst_n = 0;
        #1;
        check_eq("t6_busy", 64'(busy), 64'd0);
        check_eq("t6_trig_cnt", 64'(trig_cnt), 64'd0);
        check_eq("t6_last_gap", 64'(last_gap), 64'd0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1;
        send_hdr();
        idle(1);
        check_eq("t6_trig_cnt_after", 64'(trig_cnt), 64'd1);

        // Randomized traffic
        rand_clr = 1;
        for (int it = 0; it < 2500; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                send_hdr();
                idle($urandom_range(0, 12));
            end else if (r < 8) begin
                int n;
                n = $urandom_range(1, 6);
                for (int k = 0; k < n; k++) send_bit($urandom_range(0, 2) == 0);
            end else if (r == 8) begin
                in_live = 0;
                idle($urandom_range(1, 3));
                in_live = 1;
            end else begin
                user_min_gap = $urandom_range(0, 20);
            end
        end
        rand_clr = 0;
        clr_cnt  = 0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delta_trig_decoder.md
Name: delta_trig_decoder

Overview:
Receives the serial test-trigger line produced by the delta trigger generator, i.e. a 4-cycle header 1-0-0-1 separated by programmable gaps. Validates each header and emits one single-cycle trigger pulse per good header to the downstream CDT trigger logic. Counts good and malformed headers, flags headers that arrive closer than a minimum spacing, and reports the measured gap between headers.

Parameters:
CNT_W, 16, width of good/error counters (saturating)
GAP_W, 32, width of gap counter and gap registers

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_live  input  1  run-live gate; low forces decoder idle
in_trig  input  1  serial header line from the generator
user_min_gap  input  GAP_W  minimum allowed cycles between header starts
clr_cnt  input  1  synchronous clear of trig_cnt, err_cnt, last_gap
trig_out  output  1  one-cycle pulse per accepted header
trig_cnt  output  CNT_W  accepted headers, saturating
err_cnt  output  CNT_W  malformed or too-close headers, saturating
last_gap  output  GAP_W  gap_cnt captured at start of last accepted header
busy  output  1  high while FSM is not IDLE

Behaviour:
- Reset (rst_n low, async): state IDLE; trig_out=0, trig_cnt=0, err_cnt=0, last_gap=0, busy=0; gap_cnt=0, close_flag=0.
- All logic is registered on posedge clk; in_trig is sampled directly, with no synchroniser, because it is on the same clock domain.
- FSM states: IDLE, H1 (first 1 seen), H2 (1-0 seen), H3 (1-0-0 seen).
  - IDLE: in_trig=1 -> H1; latch start_gap=gap_cnt; close_flag = (gap_cnt < user_min_gap) && seen_one; clear gap_cnt to 1.
  - H1: in_trig=0 -> H2. in_trig=1 -> error, then restart as a new header start, following the IDLE->H1 rules.
  - H2: in_trig=0 -> H3. in_trig=1 -> error, then restart at H1 as above.
  - H3: in_trig=1 -> header complete -> IDLE. in_trig=0 -> error -> IDLE.
- Header complete:
  - If close_flag=0: trig_out=1 on the next cycle (latency 1 clk after the final 1 is sampled), trig_cnt+1, last_gap<=start_gap.
  - If close_flag=1: no trig_out, err_cnt+1, last_gap unchanged.
- Each error increments err_cnt by exactly 1. Never more than one increment per cycle.
- trig_out is high for exactly one cycle. Back-to-back pulses are impossible because the minimum header length is 4 cycles.
- gap_cnt:
  - Increments every live cycle, including during a header.
  - Saturates at all-ones.
  - seen_one is set after the first header start following in_live rising; the first header after live is never flagged close.
- Counters: trig_cnt and err_cnt saturate at all-ones; they do not wrap.
- clr_cnt=1: trig_cnt, err_cnt, last_gap <= 0. This has priority over a same-cycle increment, so the increment is lost.
- in_live=0 (any cycle, including mid-header):
  - Next state IDLE; trig_out=0; gap_cnt=0; seen_one=0; close_flag=0.
  - A partial header is discarded without an error count.
  - Counters and last_gap are held, not cleared.
- in_live rising: decoding starts on the same cycle; a 1 on that cycle is a valid header start.
- busy = (state != IDLE), registered together with the state.

Test Plan:
1. Reset, in_live=1, user_min_gap=10. Drive 1,0,0,1, then 20 zeros, then 1,0,0,1 -> two trig_out pulses, each 1 cycle after the final 1; trig_cnt=2, err_cnt=0, last_gap=24.
2. Drive 1,1,0,0,1 -> err_cnt=1 (second 1 restarts the header), then the header completes: trig_cnt=1, one trig_out. Drive 1,0,1,0,0,1 -> err_cnt+1, trig_cnt+1. Drive 1,0,0,0 -> err_cnt+1, FSM IDLE, busy=0.
3. user_min_gap=10; send two good headers with starts 6 cycles apart -> first accepted; second gives err_cnt=1, no pulse, last_gap unchanged.
4. Drop in_live during H2 -> FSM IDLE next cycle, no error or trig. Raise in_live and send a header 2 cycles later with min_gap=100 -> accepted (first after live is never close).
5. Preload trig_cnt to 0xFFFE via 65534 headers (or force), then send 3 headers -> trig_cnt stays 0xFFFF, trig_out still pulses each time. Assert clr_cnt on the same cycle as a completing header -> counters 0 and trig_out still pulses.
6. Assert rst_n low mid-header in H3 -> all outputs 0 immediately, without waiting for a clock edge. Release, then send a good header -> trig_cnt=1.
